// File: rtl/cpu_output_serializer.sv
// cpu_output_serializer
//   Captures 32-bit words strobed out of the cpu into a FIFO and drains them
//   as big-endian bytes over a valid/ready byte link. Words strobed while the
//   FIFO is full are dropped and flagged on a sticky overflow bit.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   cpu_output_data   : word from the cpu
//   cpu_output_ready  : one-cycle write strobe from the cpu (no acknowledge)
//   byte_data/valid   : byte to sink, MSB of the word first
//   byte_ready        : sink accepts byte this cycle
//   fifo_count        : words held in FIFO (excludes word in the serializer)
//   fifo_full/empty   : FIFO status
//   overflow          : sticky, at least one word was dropped
//   busy              : serializer sending or FIFO non-empty
module cpu_output_serializer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_output_data,
    input  logic              cpu_output_ready,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    localparam logic [ADDR_W:0]   C_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = 1;

    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    state_t            r_state;
    logic [31:0]       r_sh;
    logic [1:0]        r_byte_idx;

    state_t            w_next_state;
    logic              w_load;
    logic              w_shift;
    logic              w_push;

    assign fifo_count = r_count;
    assign fifo_full  = (r_count == C_FULL);
    assign fifo_empty = (r_count == '0);
    assign overflow   = r_overflow;
    assign byte_valid = (r_state == S_SEND);
    assign byte_data  = r_sh[31:24];
    assign busy       = (r_state == S_SEND) | ~fifo_empty;

    // Full is judged on pre-edge state, so a pop on the same edge never
    // rescues a strobe into a full FIFO.
    assign w_push = cpu_output_ready & ~fifo_full;

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cpu_output_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (cpu_output_ready && fifo_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and datapath controls. The last byte of a word reloads
    // directly from the FIFO so back-to-back words have no bubble.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_load       = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_ready) begin
                    if (r_byte_idx == 2'd3) begin
                        if (!fifo_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Shift register: top byte is always the byte on offer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh       <= '0;
            r_byte_idx <= '0;
        end else if (w_load) begin
            r_sh       <= r_mem[r_rd_ptr];
            r_byte_idx <= '0;
        end else if (w_shift) begin
            r_sh       <= {r_sh[23:0], 8'h00};
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

endmodule
